// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA memory arbiters: FSM state encoding and
// elaboration-time helpers.
package vga_arb_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CRT_SEL  = 3'd1;
  localparam logic [2:0] ST_CRT_XFER = 3'd2;
  localparam logic [2:0] ST_CLI_XFER = 3'd3;
  localparam logic [2:0] ST_TURN     = 3'd4;

  // Number of bits needed to index n items (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_mem_arb_n_if.sv
// Request/grant bundle between the VGA memory arbiter and its requesters.
interface vga_mem_arb_n_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned NUM_BUF = 2,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned BSEL_W  = 1
);

  logic               crt_req;
  logic [NUM_REQ-1:0] cli_req;
  logic [NUM_BUF-1:0] buf_empty;
  logic [NUM_BUF-1:0] buf_full_done;
  logic               sync_crt_line_end;
  logic               rr_mode;
  logic [CNT_W-1:0]   max_cycles;
  logic               crt_gnt;
  logic [BSEL_W-1:0]  crt_buf_sel;
  logic [NUM_REQ-1:0] cli_gnt;
  logic               arb_busy;

  modport master (
    output crt_req, cli_req, buf_empty, buf_full_done, sync_crt_line_end,
           rr_mode, max_cycles,
    input  crt_gnt, crt_buf_sel, cli_gnt, arb_busy
  );

  modport slave (
    input  crt_req, cli_req, buf_empty, buf_full_done, sync_crt_line_end,
           rr_mode, max_cycles,
    output crt_gnt, crt_buf_sel, cli_gnt, arb_busy
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational requester pick: lowest set index in fixed mode, or first set
// index at/after ptr (wrapping) in round-robin mode.
module arb_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               rr_mode,
  output logic               valid,
  output logic [PTR_W-1:0]   idx
);

  always_comb begin
    int unsigned start;
    int unsigned j;
    valid = 1'b0;
    idx   = '0;
    start = 0;
    j     = 0;
    if (rr_mode && (32'(ptr) < NUM_REQ)) start = 32'(ptr);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = start + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!valid && req[j[PTR_W-1:0]]) begin
        valid = 1'b1;
        idx   = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/vga_mem_arb_n.sv
// Display memory port arbiter: CRT line-buffer fill has top priority, general
// clients share the port by fixed priority or round-robin with a timeout.
module vga_mem_arb_n
  import vga_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned NUM_BUF = 2,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned BSEL_W  = 1
) (
  input logic            mem_clk,
  input logic            hreset_n,
  vga_mem_arb_n_if.slave bus
);

  localparam int unsigned IDX_W = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_after_pick;
  logic               pick_valid;
  logic [CNT_W-1:0]   own_cnt;
  logic [BSEL_W-1:0]  buf_sel;
  logic [BSEL_W-1:0]  empty_idx;
  logic               empty_valid;
  logic [NUM_REQ-1:0] owner_oh;
  logic               others_pending;
  logic               timeout;
  logic               crt_done;
  logic               cli_done;

  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (IDX_W)
  ) u_pick (
    .req     (bus.cli_req),
    .ptr     (rr_ptr),
    .rr_mode (bus.rr_mode),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  always_comb begin
    empty_valid = 1'b0;
    empty_idx   = '0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (!empty_valid && bus.buf_empty[i]) begin
        empty_valid = 1'b1;
        empty_idx   = BSEL_W'(i);
      end
    end
  end

  assign ptr_after_pick = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // Forced release only matters when someone else is waiting for the port.
  assign others_pending = bus.crt_req | (|(bus.cli_req & ~owner_oh));
  assign timeout  = (bus.max_cycles != '0) && (own_cnt == bus.max_cycles) && others_pending;
  assign cli_done = ~bus.cli_req[owner] | timeout;
  assign crt_done = bus.buf_full_done[buf_sel] | bus.sync_crt_line_end;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.crt_req)     state_nxt = ST_CRT_SEL;
        else if (pick_valid) state_nxt = ST_CLI_XFER;
      end
      ST_CRT_SEL:  state_nxt = empty_valid ? ST_CRT_XFER : ST_IDLE;
      ST_CRT_XFER: if (crt_done) state_nxt = ST_TURN;
      ST_CLI_XFER: if (cli_done) state_nxt = ST_TURN;
      ST_TURN:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      own_cnt <= '0;
      buf_sel <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && !bus.crt_req && pick_valid) begin
        owner   <= pick_idx;
        rr_ptr  <= ptr_after_pick;
        own_cnt <= CNT_W'(1);
      end else if ((state == ST_CLI_XFER) && (own_cnt != '1)) begin
        own_cnt <= own_cnt + 1'b1;
      end
      if ((state == ST_CRT_SEL) && empty_valid) buf_sel <= empty_idx;
    end
  end

  assign bus.crt_gnt     = (state == ST_CRT_XFER);
  assign bus.cli_gnt     = (state == ST_CLI_XFER) ? owner_oh : '0;
  assign bus.arb_busy    = (state != ST_IDLE);
  assign bus.crt_buf_sel = buf_sel;

endmodule

// File: tb/tb_vga_mem_arb_n.sv
// Directed bench for vga_mem_arb_n with hand-computed expectations.
module tb_vga_mem_arb_n;

  logic mem_clk;
  logic hreset_n;
  int   tests_run;
  int   tests_failed;

  vga_mem_arb_n_if #(.NUM_REQ(3), .NUM_BUF(2), .CNT_W(6), .BSEL_W(1)) bus ();

  vga_mem_arb_n #(
    .NUM_REQ (3),
    .NUM_BUF (2),
    .CNT_W   (6),
    .BSEL_W  (1)
  ) dut (
    .mem_clk  (mem_clk),
    .hreset_n (hreset_n),
    .bus      (bus)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic rr_round(input logic [2:0] exp);
    bus.cli_req = 3'b111;
    tick();
    chk("rr_grant", 32'(bus.cli_gnt), 32'(exp));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_hold", 32'(bus.cli_gnt), 32'(exp));
    end
    bus.cli_req = 3'b111 & ~exp;
    tick();
    chk("rr_turn", 32'(bus.cli_gnt), 32'd0);
    bus.cli_req = 3'b111;
    tick();
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    hreset_n          = 1'b0;
    bus.crt_req       = 1'b0;
    bus.cli_req       = '0;
    bus.buf_empty     = '0;
    bus.buf_full_done = '0;
    bus.sync_crt_line_end = 1'b0;
    bus.rr_mode       = 1'b0;
    bus.max_cycles    = '0;
    tick();
    tick();
    chk("rst_crt_gnt", 32'(bus.crt_gnt), 32'd0);
    chk("rst_cli_gnt", 32'(bus.cli_gnt), 32'd0);
    chk("rst_busy", 32'(bus.arb_busy), 32'd0);
    chk("rst_bsel", 32'(bus.crt_buf_sel), 32'd0);
    hreset_n = 1'b1;

    // client latency
    tick();
    bus.cli_req = 3'b010;
    #1 chk("lat_no_comb", 32'(bus.cli_gnt), 32'd0);
    tick();
    chk("lat_gnt", 32'(bus.cli_gnt), 32'b010);
    chk("lat_busy", 32'(bus.arb_busy), 32'd1);
    bus.cli_req = 3'b000;
    tick();
    chk("lat_turn_gnt", 32'(bus.cli_gnt), 32'd0);
    chk("lat_turn_busy", 32'(bus.arb_busy), 32'd1);
    tick();
    chk("lat_idle_busy", 32'(bus.arb_busy), 32'd0);

    // CRT priority and buffer select
    bus.crt_req   = 1'b1;
    bus.cli_req   = 3'b111;
    bus.buf_empty = 2'b10;
    tick();
    chk("crt_sel_crt", 32'(bus.crt_gnt), 32'd0);
    chk("crt_sel_cli", 32'(bus.cli_gnt), 32'd0);
    chk("crt_sel_busy", 32'(bus.arb_busy), 32'd1);
    tick();
    chk("crt_xfer_gnt", 32'(bus.crt_gnt), 32'd1);
    chk("crt_xfer_bsel", 32'(bus.crt_buf_sel), 32'd1);
    chk("crt_xfer_cli", 32'(bus.cli_gnt), 32'd0);
    bus.crt_req       = 1'b0;
    bus.buf_full_done = 2'b10;
    tick();
    chk("crt_done_turn", 32'(bus.crt_gnt), 32'd0);
    chk("crt_done_cli", 32'(bus.cli_gnt), 32'd0);
    bus.buf_full_done = 2'b00;
    tick();
    chk("crt_idle_busy", 32'(bus.arb_busy), 32'd0);
    tick();
    chk("crt_then_cli", 32'(bus.cli_gnt), 32'b001);
    bus.cli_req = 3'b000;
    tick();
    tick();

    // CRT abort on line end; done on the other buffer is ignored
    bus.crt_req   = 1'b1;
    bus.buf_empty = 2'b01;
    tick();
    tick();
    chk("abort_gnt", 32'(bus.crt_gnt), 32'd1);
    chk("abort_bsel", 32'(bus.crt_buf_sel), 32'd0);
    bus.crt_req       = 1'b0;
    bus.buf_full_done = 2'b10;
    tick();
    chk("abort_wrong_buf", 32'(bus.crt_gnt), 32'd1);
    bus.buf_full_done     = 2'b00;
    bus.sync_crt_line_end = 1'b1;
    tick();
    chk("abort_line_end", 32'(bus.crt_gnt), 32'd0);
    bus.sync_crt_line_end = 1'b0;
    tick();
    chk("abort_idle", 32'(bus.arb_busy), 32'd0);

    // no empty buffer
    bus.crt_req   = 1'b1;
    bus.buf_empty = 2'b00;
    tick();
    chk("noempty_sel_busy", 32'(bus.arb_busy), 32'd1);
    chk("noempty_sel_gnt", 32'(bus.crt_gnt), 32'd0);
    bus.crt_req = 1'b0;
    tick();
    chk("noempty_idle", 32'(bus.arb_busy), 32'd0);
    chk("noempty_gnt", 32'(bus.crt_gnt), 32'd0);

    // timeout: rr_ptr is 1 here, so client 2 follows client 0
    bus.rr_mode    = 1'b1;
    bus.max_cycles = 6'd5;
    bus.cli_req    = 3'b001;
    tick();
    chk("to_gnt_c1", 32'(bus.cli_gnt), 32'b001);
    bus.cli_req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_hold", 32'(bus.cli_gnt), 32'b001);
    end
    tick();
    chk("to_release", 32'(bus.cli_gnt), 32'd0);
    chk("to_turn_busy", 32'(bus.arb_busy), 32'd1);
    tick();
    chk("to_idle", 32'(bus.arb_busy), 32'd0);
    tick();
    chk("to_next_owner", 32'(bus.cli_gnt), 32'b100);
    bus.max_cycles = 6'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_unlimited", 32'(bus.cli_gnt), 32'b100);
    end
    bus.cli_req = 3'b000;
    tick();
    tick();

    // round-robin fairness, then fixed priority with the same pattern
    rr_round(3'b001);
    rr_round(3'b010);
    rr_round(3'b100);
    rr_round(3'b001);
    bus.rr_mode = 1'b0;
    rr_round(3'b001);
    rr_round(3'b001);
    rr_round(3'b001);
    bus.cli_req = 3'b000;
    tick();

    // asynchronous reset mid-transfer; rr_ptr was 1 beforehand
    bus.crt_req   = 1'b1;
    bus.buf_empty = 2'b10;
    tick();
    tick();
    chk("ares_pre_gnt", 32'(bus.crt_gnt), 32'd1);
    chk("ares_pre_bsel", 32'(bus.crt_buf_sel), 32'd1);
    bus.crt_req = 1'b0;
    #3 hreset_n = 1'b0;
    #1;
    chk("ares_crt_gnt", 32'(bus.crt_gnt), 32'd0);
    chk("ares_busy", 32'(bus.arb_busy), 32'd0);
    chk("ares_bsel", 32'(bus.crt_buf_sel), 32'd0);
    tick();
    hreset_n    = 1'b1;
    bus.rr_mode = 1'b1;
    bus.cli_req = 3'b111;
    tick();
    chk("ares_rr_ptr0", 32'(bus.cli_gnt), 32'b001);
    bus.cli_req = 3'b000;
    tick();
    tick();
    chk("end_idle", 32'(bus.arb_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_mem_arb_n.md
Name: vga_mem_arb_n

Overview:
Parametrised memory arbiter for the VGA memory controller. Grants the display memory port to one CRT line-buffer fill channel and NUM_REQ general clients (cpu write, cpu read, blitter, ...).
- CRT always has top priority; it fills whichever of NUM_BUF line buffers is empty.
- Clients arbitrate by fixed priority or round-robin, selected at run time.
- Adds a programmable ownership timeout and a one-cycle bus turnaround after every release.

Parameters:
NUM_REQ, 3, number of general clients (index 0 = highest fixed priority)
NUM_BUF, 2, number of CRT line buffers
CNT_W, 6, width of the ownership cycle counter and of max_cycles
BSEL_W, 1, width of crt_buf_sel; must be >= clog2(NUM_BUF), minimum 1

Ports:
mem_clk  input  1  memory clock; single clock domain
hreset_n  input  1  asynchronous active-low reset
crt_req  input  1  CRT requests a line-buffer fill
cli_req  input  NUM_REQ  client requests, level, held until done
buf_empty  input  NUM_BUF  per-buffer empty flags
buf_full_done  input  NUM_BUF  per-buffer fill-complete pulse/level
sync_crt_line_end  input  1  line end, synchronised to mem_clk; aborts CRT fill
rr_mode  input  1  1 = round-robin among clients, 0 = fixed priority
max_cycles  input  CNT_W  client ownership limit in cycles; 0 = unlimited
crt_gnt  output  1  CRT owns the port
crt_buf_sel  output  BSEL_W  buffer being filled, valid while crt_gnt
cli_gnt  output  NUM_REQ  one-hot client grant
arb_busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous on hreset_n low and overrides everything, including mid-transfer. All outputs go to 0 immediately. State = IDLE, rr_ptr = 0, own_cnt = 0, crt_buf_sel register = 0.
- Outputs are decoded from registered state only; no combinational path from any request input to any grant.
- States: IDLE, CRT_SEL, CRT_XFER, CLI_XFER, TURN.
- IDLE:
  - crt_req -> CRT_SEL.
  - else any cli_req -> CLI_XFER; owner = picked index, own_cnt = 1.
  - else stay in IDLE.
- Client latency: cli_req sampled high in IDLE at edge k gives cli_gnt high from edge k onward (first cycle after k).
- CRT_SEL (1 cycle, no grant):
  - Latch crt_buf_sel = lowest index i with buf_empty[i] = 1, then -> CRT_XFER.
  - If no buffer is empty -> IDLE.
- CRT_XFER:
  - crt_gnt = 1.
  - Exit to TURN when buf_full_done[crt_buf_sel] or sync_crt_line_end is high.
  - Never subject to the timeout.
- CLI_XFER:
  - cli_gnt[owner] = 1.
  - Exit to TURN when cli_req[owner] = 0.
  - Also exit to TURN (forced release) when max_cycles != 0, own_cnt == max_cycles, and any other request (crt_req or another cli_req bit) is pending.
  - own_cnt increments each cycle and saturates at all-ones.
  - A forced-off client keeps requesting and re-arbitrates normally.
- TURN (1 cycle, no grants): -> IDLE. Back-to-back owners are therefore separated by one idle port cycle, plus one more cycle (IDLE) before the next grant.
- Client pick:
  - Fixed mode: lowest set index.
  - Round-robin mode: first set index at or after rr_ptr, wrapping modulo NUM_REQ.
  - On every entry to CLI_XFER, rr_ptr = owner+1, wrapping NUM_REQ-1 -> 0. rr_ptr is also updated in fixed mode.
- Simultaneous events:
  - crt_req and cli_req together in IDLE: CRT wins.
  - buf_full_done and line_end together: single exit to TURN.
  - Owner drops its request in the same cycle the timeout fires: normal release, identical result.
- rr_mode and max_cycles may change at any time; they take effect at the next pick or next compare.
- At most one grant bit is ever set across crt_gnt and cli_gnt.

Decomposition:
- Package vga_arb_pkg holds:
  - the state encoding: IDLE=0, CRT_SEL=1, CRT_XFER=2, CLI_XFER=3, TURN=4, 3 bits;
  - a clog2 constant function.
- Sub-module arb_rr_pick: purely combinational. Inputs req[NUM_REQ], ptr, rr_mode. Outputs valid and idx. Reused by future arbiters.
- Top-level block contains the FSM, own_cnt, rr_ptr and buffer select.

Test Plan:
- Reset and client latency: hreset_n released; cli_req = 3'b010 -> cli_gnt = 010 starting the cycle after the sampling edge. Drop req -> TURN, IDLE, arb_busy = 0.
- CRT priority and buffer select: crt_req = 1 with cli_req = 111, buf_empty = 2'b10 -> one cycle with no grant, then crt_gnt = 1 and crt_buf_sel = 1. Pulse buf_full_done[1] -> TURN, then the client grant follows.
- CRT abort and no-empty case: sync_crt_line_end mid-fill ends crt_gnt next cycle. crt_req with buf_empty = 00 -> CRT_SEL, then IDLE, no grant.
- Round-robin fairness: rr_mode = 1 with cli_req = 111 held throughout; each owner drops its req for one cycle after 4 cycles of grant -> grants rotate 0,1,2,0; in fixed mode the same sequence yields 0,0,0.
- Timeout: max_cycles = 5, client 0 holds req, client 2 requests -> cli_gnt[0] low after exactly 5 cycles, one TURN cycle, then client 2 is granted. With max_cycles = 0, no forced release.
- Reset mid-transfer: assert hreset_n during CRT_XFER -> crt_gnt and arb_busy drop asynchronously; rr_ptr = 0 after release.
